// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port word-addressed
// data memory between the CPU load/store path (port A) and a secondary
// master (port B). Grants are registered. Each access is acknowledged in
// the cycle it is presented to memory. Out-of-range or misaligned
// addresses are acknowledged with an error and never reach the memory
// write enable.
module dmem_arbiter #(
    parameter int DEPTH    = 4000,
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        aReq,
    input  logic        aWrEn,
    input  logic [31:0] aAddr,
    input  logic [31:0] aDataIn,
    output logic        aAck,
    output logic        aErr,
    output logic [31:0] aDataOut,

    input  logic        bReq,
    input  logic        bWrEn,
    input  logic [31:0] bAddr,
    input  logic [31:0] bDataIn,
    output logic        bAck,
    output logic        bErr,
    output logic [31:0] bDataOut,

    output logic        memWrEn,
    output logic [31:0] memAddr,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    localparam logic        GRANT_A    = 1'b0;
    localparam logic        GRANT_B    = 1'b1;
    localparam logic [29:0] DEPTH_WORD = 30'(DEPTH);
    localparam logic [7:0]  MAX_BURST  = 8'(MAXBURST);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  burst_cnt_q;
    logic [7:0]  burst_cnt_d;
    logic        last_grant_q;
    logic        last_grant_d;

    logic        a_bad_addr;
    logic        b_bad_addr;
    logic [8:0]  burst_inc;
    logic        burst_limit;
    logic [7:0]  burst_sat;

    // Address legality for each port: word index must be inside the memory and the byte offset must be zero.
    always_comb begin
        a_bad_addr = (aAddr[31:2] >= DEPTH_WORD) || (aAddr[1:0] != 2'b00);
        b_bad_addr = (bAddr[31:2] >= DEPTH_WORD) || (bAddr[1:0] != 2'b00);
    end

    // Burst bookkeeping: the count after this transfer, whether it reaches the cap, and its saturated value.
    always_comb begin
        burst_inc   = {1'b0, burst_cnt_q} + 9'd1;
        burst_limit = (burst_inc >= {1'b0, MAX_BURST});
        burst_sat   = burst_limit ? MAX_BURST : burst_inc[7:0];
    end

    // Next-state logic: round-robin on ties from IDLE, burst cap on handover, release cycles on dropped requests.
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = 8'd0;
                if (aReq && bReq) begin
                    state_d = (last_grant_q == GRANT_B) ? SERVE_A : SERVE_B;
                end else if (aReq) begin
                    state_d = SERVE_A;
                end else if (bReq) begin
                    state_d = SERVE_B;
                end
            end
            SERVE_A: begin
                if (aReq) begin
                    last_grant_d = GRANT_A;
                    if (bReq && burst_limit) begin
                        state_d     = SERVE_B;
                        burst_cnt_d = 8'd0;
                    end else begin
                        burst_cnt_d = burst_sat;
                    end
                end else begin
                    burst_cnt_d = 8'd0;
                    state_d     = bReq ? SERVE_B : IDLE;
                end
            end
            SERVE_B: begin
                if (bReq) begin
                    last_grant_d = GRANT_B;
                    if (aReq && burst_limit) begin
                        state_d     = SERVE_A;
                        burst_cnt_d = 8'd0;
                    end else begin
                        burst_cnt_d = burst_sat;
                    end
                end else begin
                    burst_cnt_d = 8'd0;
                    state_d     = aReq ? SERVE_A : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // Memory and port outputs: granted port is muxed onto the memory; reset suppresses every strobe so no write slips through.
    always_comb begin
        memWrEn   = 1'b0;
        memAddr   = 32'd0;
        memDataIn = 32'd0;
        aAck      = 1'b0;
        aErr      = 1'b0;
        aDataOut  = 32'd0;
        bAck      = 1'b0;
        bErr      = 1'b0;
        bDataOut  = 32'd0;
        case (state_q)
            SERVE_A: begin
                memAddr   = aAddr;
                memDataIn = aDataIn;
                if (aReq) begin
                    aAck    = 1'b1;
                    aErr    = a_bad_addr;
                    memWrEn = aWrEn && !a_bad_addr;
                    if (!a_bad_addr && !aWrEn) begin
                        aDataOut = memDataOut;
                    end
                end
            end
            SERVE_B: begin
                memAddr   = bAddr;
                memDataIn = bDataIn;
                if (bReq) begin
                    bAck    = 1'b1;
                    bErr    = b_bad_addr;
                    memWrEn = bWrEn && !b_bad_addr;
                    if (!b_bad_addr && !bWrEn) begin
                        bDataOut = memDataOut;
                    end
                end
            end
            default: begin
                memAddr   = 32'd0;
                memDataIn = 32'd0;
            end
        endcase
        if (reset) begin
            memWrEn  = 1'b0;
            aAck     = 1'b0;
            aErr     = 1'b0;
            aDataOut = 32'd0;
            bAck     = 1'b0;
            bErr     = 1'b0;
            bDataOut = 32'd0;
        end
    end

    // State registers; B is recorded as last grant on reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_cnt_q  <= 8'd0;
            last_grant_q <= GRANT_B;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port word-addressed data memory between the CPU load/store path (port A) and a secondary master such as a loader or DMA (port B). It holds a registered grant, forwards the granted port's address, data and write enable to the memory, and returns an acknowledge and read data in the access cycle. It caps consecutive accesses by one port when the other is waiting, and rejects out-of-range or misaligned addresses without touching memory.

## Interface
- DEPTH, 4000: memory size in 32-bit words; valid byte addresses are 0 .. 4*DEPTH-4.
- MAXBURST, 4: maximum consecutive completed accesses by one port while the other port is requesting; legal range 1..255.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- aReq, bReq  in  1  request; the port holds it high with stable WrEn/Addr/DataIn until it sees Ack.
- aWrEn, bWrEn  in  1  1 = write, 0 = read.
- aAddr, bAddr  in  32  byte address.
- aDataIn, bDataIn  in  32  write data.
- aAck, bAck  out  1  access completed this cycle (combinational).
- aErr, bErr  out  1  with Ack: address out of range or addr[1:0] != 0.
- aDataOut, bDataOut  out  32  read data, valid when Ack=1 and Err=0; 0 otherwise.
- memWrEn  out  1  memory write enable.
- memAddr  out  32  memory byte address.
- memDataIn  out  32  memory write data.
- memDataOut  in  32  memory combinational read data.

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B.
- Registers: state, burstCnt (8 bits), lastGrant (A/B).
- IDLE:
  - Drives memWrEn=0, memAddr=0, memDataIn=0. No Ack.
  - Next state: if only one port requests, grant it. If both request, grant the port != lastGrant. burstCnt <= 0.
- SERVE_X: memAddr=xAddr, memDataIn=xDataIn.
- SERVE_X with xReq=1 (transfer cycle):
  - xAck=1.
  - xErr=1 if xAddr[31:2] >= DEPTH or xAddr[1:0] != 0.
  - memWrEn = xWrEn & !xErr.
  - xDataOut = memDataOut if !xErr and read; 0 otherwise.
  - burstCnt <= burstCnt+1; lastGrant <= X.
  - If the other port requests and burstCnt+1 >= MAXBURST, next state is SERVE_other with burstCnt <= 0. Otherwise stay in SERVE_X.
- SERVE_X with xReq=0 (release cycle): no access, no Ack. Next state is SERVE_other if that port requests, else IDLE.
- Back-to-back streaming: a port that keeps Req high after Ack presents its next request. This gives one access per cycle while it holds the grant.
- The non-granted port always sees Ack=0, Err=0, DataOut=0.
- Error accesses count toward burstCnt and update lastGrant like normal accesses.

## Timing
- Reset, while reset=1:
  - state <= IDLE, burstCnt <= 0, lastGrant <= B, so A wins the first tie.
  - memWrEn, aAck, bAck, aErr, bErr forced to 0 combinationally, even if state is SERVE_X. This means no write can occur during a reset cycle.
  - An access in flight when reset asserts is dropped. The requester must reissue it.
- Grant latency from IDLE: Req first high in cycle N, grant and Ack in cycle N+1.
- Handover when the other port is waiting:
  - After the MAXBURST-th transfer, the other port's Ack follows in the next cycle (zero dead cycles).
  - After a release cycle, there is one dead cycle.
- Memory write commits at the rising edge ending the Ack cycle. Read data is combinational in the Ack cycle.
- Simultaneous requests from IDLE: round-robin by lastGrant.
- MAXBURST=1: strict alternation while both ports request.
- burstCnt never exceeds MAXBURST. It saturates and does not wrap when no competitor is present.

## Test plan
- After reset, idle, both ports request in the same cycle -> A acked first; with both held, A gets accesses 1-4, then B gets 4 (MAXBURST=4), with no dead cycle at either handover.
- Port A write 0xDEADBEEF to addr 8, then read addr 8 -> write Ack with memWrEn=1; read Ack returns 0xDEADBEEF, Err=0.
- Port B writes addr 16000 (word 4000), then addr 6 -> both acked with bErr=1, memWrEn=0 each cycle, bDataOut=0; memory contents unchanged.
- A streams 10 reads with B idle -> 10 consecutive Acks, grant never leaves A; A drops Req -> one release cycle -> IDLE.
- Reset asserted during a SERVE_A write cycle -> memWrEn=0 and aAck=0 that cycle; next cycle state IDLE; target word unchanged.
- A releases while B requests -> A release cycle, then B acked the following cycle; lastGrant=B, so the next tie goes to A.
